queue_fifo: RTL and testbench



---
 rtl/queue_pkg.sv | 16 +
 rtl/queue_fifo_if.sv | 31 +++
 rtl/queue_ram.sv | 27 ++
 rtl/queue_fifo.sv | 81 ++++++++
 tb/tb_queue_fifo.sv | 161 ++++++++++++++++
 5 files changed

// File: rtl/queue_pkg.sv
// Shared sizing defaults and pointer/count types for the circular FIFO queue.
package queue_pkg;

    localparam int unsigned QUEUE_WORD_WIDTH = 32;
    localparam int unsigned QUEUE_DEPTH      = 256;

    function automatic int unsigned addr_width(input int unsigned depth);
        return $clog2(depth);
    endfunction

    localparam int unsigned QUEUE_ADDR_WIDTH = addr_width(QUEUE_DEPTH);

    typedef logic [QUEUE_ADDR_WIDTH-1:0] ptr_t;
    typedef logic [QUEUE_ADDR_WIDTH:0]   count_t;

endpackage

// File: rtl/queue_fifo_if.sv
// PUSH/POP/Input/OUTPUT queue bus, shared in style with the LIFO stack block.
interface queue_fifo_if
    import queue_pkg::*;
#(
    parameter int unsigned WORD_WIDTH = QUEUE_WORD_WIDTH,
    parameter int unsigned DEPTH      = QUEUE_DEPTH
);

    localparam int unsigned ADDR_WIDTH = addr_width(DEPTH);

    logic                  PUSH;
    logic                  POP;
    logic [WORD_WIDTH-1:0] Input;
    logic [WORD_WIDTH-1:0] OUTPUT;
    logic                  EMPTY;
    logic                  FULL;
    logic [ADDR_WIDTH:0]   COUNT;
    logic                  OVERFLOW;
    logic                  UNDERFLOW;

    modport master (
        output PUSH, POP, Input,
        input  OUTPUT, EMPTY, FULL, COUNT, OVERFLOW, UNDERFLOW
    );

    modport slave (
        input  PUSH, POP, Input,
        output OUTPUT, EMPTY, FULL, COUNT, OVERFLOW, UNDERFLOW
    );

endinterface

// File: rtl/queue_ram.sv
// DEPTH x WORD_WIDTH storage: synchronous write, asynchronous read, no reset.
module queue_ram
    import queue_pkg::*;
#(
    parameter int unsigned WORD_WIDTH = QUEUE_WORD_WIDTH,
    parameter int unsigned DEPTH      = QUEUE_DEPTH,
    localparam int unsigned ADDR_WIDTH = addr_width(DEPTH)
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] waddr,
    input  logic [WORD_WIDTH-1:0] wdata,
    input  logic [ADDR_WIDTH-1:0] raddr,
    output logic [WORD_WIDTH-1:0] rdata
);

    logic [WORD_WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/queue_fifo.sv
// Circular FIFO queue: push at tail, pop from head, zero-latency OUTPUT gated by POP.
module queue_fifo
    import queue_pkg::*;
#(
    parameter int unsigned WORD_WIDTH = QUEUE_WORD_WIDTH,
    parameter int unsigned DEPTH      = QUEUE_DEPTH
) (
    input  logic         clk,
    input  logic         rst,
    queue_fifo_if.slave  bus
);

    localparam int unsigned ADDR_WIDTH = addr_width(DEPTH);
    localparam logic [ADDR_WIDTH:0] FULL_COUNT = (ADDR_WIDTH+1)'(DEPTH);

    logic [ADDR_WIDTH-1:0] head;
    logic [ADDR_WIDTH-1:0] tail;
    logic [ADDR_WIDTH:0]   count;
    logic                  overflow;
    logic                  underflow;
    logic                  empty;
    logic                  full;
    logic                  pop_ok;
    logic                  push_ok;
    logic [WORD_WIDTH-1:0] rdata;

    assign empty = (count == '0);
    assign full  = (count == FULL_COUNT);

    // A pop frees a slot in the same edge, so a full queue may still accept a push.
    assign pop_ok  = bus.POP && !empty;
    assign push_ok = bus.PUSH && (!full || pop_ok);

    always_ff @(posedge clk) begin
        if (rst) begin
            head      <= '0;
            tail      <= '0;
            count     <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (push_ok) begin
                tail <= tail + 1'b1;
            end
            if (pop_ok) begin
                head <= head + 1'b1;
            end
            case ({push_ok, pop_ok})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            if (bus.PUSH && !push_ok) begin
                overflow <= 1'b1;
            end
            if (bus.POP && !pop_ok) begin
                underflow <= 1'b1;
            end
        end
    end

    queue_ram #(
        .WORD_WIDTH (WORD_WIDTH),
        .DEPTH      (DEPTH)
    ) u_ram (
        .clk   (clk),
        .we    (push_ok),
        .waddr (tail),
        .wdata (bus.Input),
        .raddr (head),
        .rdata (rdata)
    );

    assign bus.OUTPUT    = pop_ok ? rdata : '0;
    assign bus.EMPTY     = empty;
    assign bus.FULL      = full;
    assign bus.COUNT     = count;
    assign bus.OVERFLOW  = overflow;
    assign bus.UNDERFLOW = underflow;

endmodule

// File: tb/tb_queue_fifo.sv
// Directed bench for queue_fifo: a default 256-deep instance and a 4-deep instance.
module tb_queue_fifo;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    always #5 clk = ~clk;

    queue_fifo_if #(.WORD_WIDTH(32), .DEPTH(256)) ba ();
    queue_fifo_if #(.WORD_WIDTH(32), .DEPTH(4))   bb ();

    queue_fifo #(.WORD_WIDTH(32), .DEPTH(256)) u_a (.clk(clk), .rst(rst), .bus(ba));
    queue_fifo #(.WORD_WIDTH(32), .DEPTH(4))   u_b (.clk(clk), .rst(rst), .bus(bb));

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Inputs change after the falling edge; combinational OUTPUT is then observable.
    task automatic set_a(input logic p, input logic q, input logic [31:0] d);
        @(negedge clk);
        ba.PUSH = p; ba.POP = q; ba.Input = d;
        #1;
    endtask

    task automatic set_b(input logic p, input logic q, input logic [31:0] d);
        @(negedge clk);
        bb.PUSH = p; bb.POP = q; bb.Input = d;
        #1;
    endtask

    task automatic edge_wait();
        @(posedge clk);
        #1;
    endtask

    logic [31:0] vec3 [3];
    logic [31:0] vecb [5];

    initial begin
        vec3 = '{32'h11, 32'h22, 32'h33};
        vecb = '{32'hA0, 32'hA1, 32'hA2, 32'hA3, 32'hA4};
        ba.PUSH = 1'b0; ba.POP = 1'b0; ba.Input = '0;
        bb.PUSH = 1'b0; bb.POP = 1'b0; bb.Input = '0;

        // Reset then idle.
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        repeat (3) edge_wait();
        check("rst_count", ba.COUNT, 0);
        check("rst_empty", ba.EMPTY, 1);
        check("rst_full", ba.FULL, 0);
        check("rst_output", ba.OUTPUT, 0);
        check("rst_ovf", ba.OVERFLOW, 0);
        check("rst_unf", ba.UNDERFLOW, 0);
        check("rst_b_empty", bb.EMPTY, 1);

        // Ordering on the 256-deep queue.
        for (int i = 0; i < 3; i++) begin
            set_a(1'b1, 1'b0, vec3[i]);
            edge_wait();
        end
        check("ord_count3", ba.COUNT, 3);
        for (int i = 0; i < 3; i++) begin
            set_a(1'b0, 1'b1, 32'h0);
            check($sformatf("ord_out%0d", i), ba.OUTPUT, {32'h0, vec3[i]});
            edge_wait();
            check($sformatf("ord_cnt%0d", i), ba.COUNT, 64'(2 - i));
        end
        set_a(1'b0, 1'b0, 32'h0);
        check("ord_empty", ba.EMPTY, 1);
        check("ord_unf", ba.UNDERFLOW, 0);

        // Fill the 4-deep queue and overrun it.
        for (int i = 0; i < 5; i++) begin
            set_b(1'b1, 1'b0, vecb[i]);
            edge_wait();
            if (i == 3) begin
                check("full_flag", bb.FULL, 1);
                check("full_ovf_pre", bb.OVERFLOW, 0);
            end
        end
        check("full_ovf", bb.OVERFLOW, 1);
        check("full_count", bb.COUNT, 4);
        for (int i = 0; i < 4; i++) begin
            set_b(1'b0, 1'b1, 32'h0);
            check($sformatf("full_pop%0d", i), bb.OUTPUT, {32'h0, vecb[i]});
            edge_wait();
        end
        set_b(1'b0, 1'b0, 32'h0);
        check("full_drained", bb.EMPTY, 1);

        // Push and pop together on an empty queue: no fall-through.
        set_a(1'b1, 1'b1, 32'h55);
        check("pp_empty_out", ba.OUTPUT, 0);
        edge_wait();
        check("pp_empty_unf", ba.UNDERFLOW, 1);
        check("pp_empty_cnt", ba.COUNT, 1);
        set_a(1'b0, 1'b1, 32'h0);
        check("pp_empty_pop", ba.OUTPUT, 32'h55);
        edge_wait();
        check("pp_empty_cnt0", ba.COUNT, 0);

        // Push and pop together on a full queue, wrapping both pointers.
        for (int i = 1; i <= 4; i++) begin
            set_b(1'b1, 1'b0, 32'(i));
            edge_wait();
        end
        check("pf_full", bb.FULL, 1);
        for (int i = 5; i <= 8; i++) begin
            set_b(1'b1, 1'b1, 32'(i));
            check($sformatf("pf_out%0d", i), bb.OUTPUT, 64'(i - 4));
            edge_wait();
            check($sformatf("pf_cnt%0d", i), bb.COUNT, 4);
        end
        for (int i = 5; i <= 8; i++) begin
            set_b(1'b0, 1'b1, 32'h0);
            check($sformatf("pf_drain%0d", i), bb.OUTPUT, 64'(i));
            edge_wait();
        end
        set_b(1'b0, 1'b0, 32'h0);
        check("pf_empty", bb.EMPTY, 1);
        check("pf_unf", bb.UNDERFLOW, 0);
        check("pf_ovf_sticky", bb.OVERFLOW, 1);

        // Mid-stream reset with PUSH held.
        set_a(1'b1, 1'b0, 32'h77);
        edge_wait();
        set_a(1'b1, 1'b0, 32'h88);
        edge_wait();
        check("mr_count2", ba.COUNT, 2);
        @(negedge clk);
        rst = 1'b1;
        ba.PUSH = 1'b1; ba.POP = 1'b0; ba.Input = 32'h99;
        edge_wait();
        rst = 1'b0;
        ba.PUSH = 1'b0;
        check("mr_count", ba.COUNT, 0);
        check("mr_empty", ba.EMPTY, 1);
        check("mr_ovf", ba.OVERFLOW, 0);
        check("mr_unf", ba.UNDERFLOW, 0);
        check("mr_b_ovf", bb.OVERFLOW, 0);
        set_a(1'b0, 1'b1, 32'h0);
        check("mr_pop_out", ba.OUTPUT, 0);
        edge_wait();
        check("mr_pop_unf", ba.UNDERFLOW, 1);
        check("mr_pop_cnt", ba.COUNT, 0);
        set_a(1'b0, 1'b0, 32'h0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
